// File: rtl/mult_pkg.sv
// Shared types and constants for the shift-and-add multiplier datapath.
package mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    DONE  = 2'd2
  } mult_opreg_state_t;

  localparam int MULT_WIDTH = 8;

  // Counter must hold the value WIDTH itself, hence WIDTH+1 codes.
  function automatic int mult_cnt_w(input int width);
    return $clog2(width + 1);
  endfunction

endpackage

// File: rtl/mult_bit_cnt.sv
// Loadable down-counter with terminal-count flag; saturates at zero.
module mult_bit_cnt #(
  parameter int W = 4
) (
  input  logic         i_clk,
  input  logic         i_rst,
  input  logic         ld,
  input  logic [W-1:0] ld_val,
  input  logic         dec,
  output logic [W-1:0] cnt,
  output logic         zero
);

  assign zero = (cnt == '0);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt <= '0;
    end else if (ld) begin
      cnt <= ld_val;
    end else if (dec && !zero) begin
      cnt <= cnt - W'(1);
    end
  end

endmodule

// File: rtl/mult_operand_shreg.sv
// Multiplier-operand shift register with remaining-shift count and done flag.
// Optional MULT_OPERAND_ZERO_SKIP_EN: a zero operand finishes immediately.
//
// state | meaning
// IDLE  | waiting for the first load
// SHIFT | operand loaded, shifting right on each shift_en
// DONE  | all WIDTH shifts taken (or zero skipped), result held
module mult_operand_shreg
  import mult_pkg::*;
#(
  parameter int WIDTH = MULT_WIDTH,
  parameter int CNT_W = mult_cnt_w(WIDTH)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             ld_B,
  input  logic             shift_en,
  input  logic             ser_in,
  input  logic [WIDTH-1:0] d_in_1,
  output logic [WIDTH-1:0] out_B,
  output logic             lsb_out,
  output logic [CNT_W-1:0] cnt,
  output logic             busy,
  output logic             done
);

  mult_opreg_state_t state_q, state_d;
  logic [WIDTH-1:0]  shreg_d;
  logic              cnt_ld;
  logic [CNT_W-1:0]  cnt_ld_val;
  logic              cnt_dec;
  logic              cnt_zero;

  always_comb begin
    state_d    = state_q;
    shreg_d    = out_B;
    cnt_ld     = 1'b0;
    cnt_ld_val = CNT_W'(WIDTH);
    cnt_dec    = 1'b0;
    if (ld_B) begin
      cnt_ld  = 1'b1;
      shreg_d = d_in_1;
      state_d = SHIFT;
`ifdef MULT_OPERAND_ZERO_SKIP_EN
      if (d_in_1 == '0) begin
        cnt_ld_val = '0;
        state_d    = DONE;
      end
`endif
    end else if (state_q == SHIFT && shift_en) begin
      shreg_d = {ser_in, out_B[WIDTH-1:1]};
      cnt_dec = 1'b1;
      if (cnt == CNT_W'(1)) begin
        state_d = DONE;
      end
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q <= IDLE;
      out_B   <= '0;
    end else begin
      state_q <= state_d;
      out_B   <= shreg_d;
    end
  end

  mult_bit_cnt #(.W(CNT_W)) u_bit_cnt (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .ld     (cnt_ld),
    .ld_val (cnt_ld_val),
    .dec    (cnt_dec),
    .cnt    (cnt),
    .zero   (cnt_zero)
  );

  assign lsb_out = out_B[0];
  assign busy    = (state_q == SHIFT);
  assign done    = (state_q == DONE);

endmodule

// File: doc/mult_operand_shreg.md
# mult_operand_shreg

Parametrised multiplier-operand register for the shift-and-add multiplier datapath. It loads the multiplier operand, then shifts it right one bit per enabled cycle, presenting the current LSB to the controller for the add/skip decision. It counts the remaining shifts and flags completion, so the controller no longer keeps its own bit counter. It sits between the operand input bus and the accumulator/add-control logic and is the successor to the fixed 8-bit load-only operand register.

## Interface
Parameters:
- WIDTH, 8, operand width in bits (≥ 2)
- CNT_W, $clog2(WIDTH+1), width of the remaining-shift counter (derived; do not override)

Ports:
- i_clk  input  1  clock, rising edge
- i_rst  input  1  asynchronous, active-high reset
- ld_B  input  1  load d_in_1 and start a new operation
- shift_en  input  1  perform one right shift this cycle (honoured only in SHIFT)
- ser_in  input  1  bit shifted into the MSB (accumulator LSB in the combined A/Q scheme)
- d_in_1  input  WIDTH  operand to load
- out_B  output  WIDTH  current register contents
- lsb_out  output  1  out_B[0], combinational from the register
- cnt  output  CNT_W  shifts remaining
- busy  output  1  high in SHIFT
- done  output  1  high in DONE; level, held until the next load

## Operation
- Reset (async, any time, including mid-operation): out_B=0, cnt=0, state IDLE, busy=0, done=0.
- States: IDLE, SHIFT, DONE.
- IDLE: hold. ld_B → out_B=d_in_1, cnt=WIDTH, go to SHIFT.
- SHIFT: if shift_en, then out_B={ser_in, out_B[WIDTH-1:1]} and cnt=cnt-1. If cnt==1 at that shift, go to DONE. With shift_en=0, hold.
- DONE: hold out_B (final product low half) and cnt=0. shift_en is ignored.
- ld_B in any state (SHIFT included) reloads and restarts from SHIFT with cnt=WIDTH. ld_B has priority over a simultaneous shift_en.
- cnt never wraps. No decrement occurs outside SHIFT.
- busy = (state==SHIFT). done = (state==DONE). Both are registered-state decodes, with no combinational path from the inputs.

## Timing
- Load latency: 1 cycle. out_B, cnt and busy are updated at the edge that samples ld_B.
- Each accepted shift updates out_B, lsb_out and cnt at the same edge.
- Exactly WIDTH accepted shifts after the load, done rises at the edge of the final shift. Minimum load-to-done time is WIDTH+1 edges with shift_en held high.
- lsb_out is valid in the cycle before each shift and is used by the controller for that cycle's add decision.

## Configuration
- Macro: MULT_OPERAND_ZERO_SKIP_EN.
- Defined: a load with d_in_1==0 goes directly to DONE with out_B=0 and cnt=0. done rises one cycle after ld_B and no shifts occur.
- Undefined: a zero operand runs the full WIDTH shifts like any other value.

## Structure
- Shared package mult_pkg holds:
  - state enum mult_opreg_state_t {IDLE, SHIFT, DONE}
  - default WIDTH constant MULT_WIDTH=8
  - the CNT_W derivation function
- One sub-module, mult_bit_cnt: a loadable down-counter with a zero/terminal-count flag. It is also reused by the accumulator-side control.

## Test plan
- Reset mid-SHIFT: load 8'hA5, do 3 shifts, then pulse i_rst → out_B=0, cnt=0, busy=0, done=0 immediately, with no clock edge required.
- Load 8'hB3 with ser_in=0 and shift_en held high → lsb_out sequence 1,1,0,0,1,1,0,1. done at edge 9 after the load, out_B=0, cnt=0.
- Load 8'h0F with ser_in=1 for all shifts → final out_B=8'hFF. Gap shift_en low for 2 cycles mid-run → cnt holds and done is delayed by 2 cycles.
- ld_B together with shift_en in SHIFT (cnt=5, new d_in_1=8'h81) → out_B=8'h81, cnt=8, no shift applied. shift_en in DONE → out_B unchanged.
- WIDTH=16 instance: load 16'h8001 → done after 16 shifts, cnt decrements 16→0, and lsb_out is 1 on the first and last shifts.
- Zero operand: load 8'h00. With MULT_OPERAND_ZERO_SKIP_EN defined → done=1 one cycle later, busy never asserts. Without the macro → busy for 8 shifts, then done.
